lsu_mem_master: RTL
===================

// Module: lsu_mem_master
// PURPOSE
//  Initiator side of the data-memory port: accepts one load/store from the core, drives word-aligned
//  memory requests with byte-lane write masks, and returns extracted and extended load data.
//  Misaligned accesses are split into two aligned word accesses. A timeout flags a hung memory.
//  Sits between the execute stage and the data memory; one transaction in flight at a time.
// PARAMETERS
//  TIMEOUT   16  max cycles waiting for mem_gnt or mem_rvalid before aborting with rsp_err
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  rst_n        in   1   synchronous reset, active-low
//  req_valid    in   1   core request present
//  req_ready    out  1   block idle, can accept; transfer when req_valid & req_ready
//  req_we       in   1   1 = store, 0 = load
//  req_size     in   3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
//  req_addr     in   32  byte address, any alignment
//  req_wdata    in   32  store data, right-justified
//  mem_req      out  1   memory request; held until mem_gnt
//  mem_we       out  1   1 = write
//  mem_addr     out  32  word address, bits [1:0] always 00
//  mem_wdata    out  32  lane-positioned write data
//  mem_wmask    out  4   byte-lane enables (bit i = byte i); 0000 on reads
//  mem_gnt      in   1   memory accepted current request
//  mem_rvalid   in   1   read data valid; never in the gnt cycle, earliest one cycle after
//  mem_rdata    in   32  read word
//  rsp_valid    out  1   one-cycle completion pulse
//  rsp_rdata    out  32  load result (0 for stores / errors)
//  rsp_err      out  1   with rsp_valid: illegal size or timeout
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, timer 0; req_ready=1 from first cycle after rst_n high.
//  Reset mid-transaction: abandon immediately, mem_req low next cycle, no rsp_valid; late gnt/rvalid ignored.
//  FSM: IDLE -> REQ0 -> [WAIT0] -> (REQ1 -> [WAIT1]) -> RESP -> IDLE. WAITx for loads only.
//  IDLE: req_ready=1; on handshake latch we/size/addr/wdata; off=addr[1:0], nbytes 1/2/4.
//   split = off+nbytes>4. Illegal: size 011/110/111, or store with size[2]=1 -> RESP with err, no mem access.
//  REQ0: mem_req=1, mem_addr={addr[31:2],2'b00}; mem_addr/wdata/wmask/we stable until gnt.
//   Store wdata0 = wdata<<(8*off); wmask0 = (size mask 0001/0011/1111 << off)[3:0].
//  REQ1: mem_addr = word0+4 (wraps 0xFFFF_FFFC -> 0x0000_0000); wdata1 = wdata>>(8*(4-off));
//   wmask1 = size mask >> (4-off). Loads: wmask 0000.
//  Store completes at gnt; load completes at rvalid; low word latched from access 0, high from access 1.
//  Load assembly: 64-bit {hi,lo} >> (8*off), take nbytes; B/H sign-extend, BU/HU/W zero-extend.
//  RESP: rsp_valid=1 exactly one cycle, rsp_rdata/rsp_err valid that cycle only; then IDLE.
//  Timer: clears on entering REQx/WAITx; counts each waiting cycle; reaching TIMEOUT -> drop mem_req,
//   RESP with rsp_err=1, rsp_rdata=0; any pending access not issued.
//  Latency, aligned load, gnt in first REQ0 cycle, rvalid next: handshake cycle 0, REQ0 1, WAIT0 2,
//   RESP 3 (rsp_valid), req_ready again at 4. Aligned store: rsp_valid at cycle 2.
//  No back-to-back accept: req_ready=0 from cycle after handshake through RESP.
//  mem_gnt/mem_rvalid outside REQx/WAITx ignored.
// TESTING
//  LW 0x100, rdata 0x8899AABB -> one mem access 0x100, rsp_rdata 0x8899AABB, rsp_valid at cycle 3.
//  LB 0x103 rdata 0x80FFFF00 -> 0xFFFFFF80; LBU same -> 0x00000080; LHU 0x102 -> 0x000080FF.
//  SW 0x101 data 0x11223344 -> access1 0x100 wdata 0x22334400 mask 1110; access2 0x104 wdata 0x00000011 mask 0001.
//  LH 0xFFFFFFFF: words 0xAA000000 @0xFFFFFFFC, 0x000000BB @0x0 -> two accesses, rsp_rdata 0xFFFFBBAA.
//  mem_gnt held low 16 cycles -> mem_req drops, rsp_valid+rsp_err, rsp_rdata 0; size 011 -> err, no mem_req.
//  rst_n low during WAIT0, rvalid arrives after -> no rsp_valid, mem_req 0, req_ready 1 after reset.

Source files
------------

// File: rtl/lsu_mem_master_if.sv
// rtl/lsu_mem_master_if.sv - core request, data-memory port and response signals of lsu_mem_master
interface lsu_mem_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    input  req_valid, req_we, req_size, req_addr, req_wdata, mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    output req_valid, req_we, req_size, req_addr, req_wdata, mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - load/store unit memory initiator with misaligned split and timeout
module lsu_mem_master #(
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  lsu_mem_master_if.master bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          we_q, we_d;
  logic [2:0]    size_q, size_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   lo_q, lo_d;
  logic          req_ready_q, req_ready_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_wmask_q, mem_wmask_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    logic [3:0] m;
    case (sz)
      2'b00:   m = 4'b0001;
      2'b01:   m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic size_legal(input logic we, input logic [2:0] sz);
    logic ok;
    case (sz)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b100, 3'b101:         ok = ~we;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // The access spills into the next word when its last byte lands past lane 3.
  function automatic logic is_split(input logic [1:0] off, input logic [1:0] sz);
    logic [2:0] last;
    last = {1'b0, off} + {1'b0, sz[1], sz[1] | sz[0]};
    return last[2];
  endfunction

  function automatic logic [31:0] load_ext(input logic [63:0] d, input logic [1:0] off,
                                           input logic [2:0] sz);
    logic [31:0] w;
    logic [31:0] r;
    w = 32'(d >> {off, 3'b000});
    case (sz)
      3'b000:  r = {{24{w[7]}}, w[7:0]};
      3'b001:  r = {{16{w[15]}}, w[15:0]};
      3'b100:  r = {24'h0, w[7:0]};
      3'b101:  r = {16'h0, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  logic [31:0] word1;
  logic        split_q;
  logic        tmo;

  assign word1   = {addr_q[31:2], 2'b00} + 32'd4;
  assign split_q = is_split(addr_q[1:0], size_q[1:0]);
  assign tmo     = (timer_q == TMAX);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    we_d        = we_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lo_d        = lo_q;
    req_ready_d = req_ready_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0;
    rsp_err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (bus.req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          we_d        = bus.req_we;
          size_d      = bus.req_size;
          addr_d      = bus.req_addr;
          wdata_d     = bus.req_wdata;
          if (!size_legal(bus.req_we, bus.req_size)) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d     = REQ0;
            timer_d     = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.req_we;
            mem_addr_d  = {bus.req_addr[31:2], 2'b00};
            mem_wdata_d = bus.req_we ? (bus.req_wdata << {bus.req_addr[1:0], 3'b000}) : 32'h0;
            mem_wmask_d = bus.req_we ? (size_mask(bus.req_size[1:0]) << bus.req_addr[1:0]) : 4'b0000;
          end
        end
      end
      REQ0, REQ1: begin
        if (bus.mem_gnt) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wdata_d = 32'h0;
          mem_wmask_d = 4'b0000;
          timer_d     = '0;
          if (!we_q) begin
            state_d = (state_q == REQ0) ? WAIT0 : WAIT1;
          end else if (state_q == REQ0 && split_q) begin
            // Second store beat carries the bytes shifted out past lane 3.
            state_d     = REQ1;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = word1;
            mem_wdata_d = wdata_q >> (6'd32 - {1'b0, addr_q[1:0], 3'b000});
            mem_wmask_d = size_mask(size_q[1:0]) >> (3'd4 - {1'b0, addr_q[1:0]});
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
          end
        end else if (tmo) begin
          state_d     = RESP;
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT0, WAIT1: begin
        if (bus.mem_rvalid) begin
          timer_d = '0;
          if (state_q == WAIT0) lo_d = bus.mem_rdata;
          if (state_q == WAIT0 && split_q) begin
            state_d    = REQ1;
            mem_req_d  = 1'b1;
            mem_addr_d = word1;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = load_ext((state_q == WAIT0) ? {32'h0, bus.mem_rdata} : {bus.mem_rdata, lo_q},
                                   addr_q[1:0], size_q);
          end
        end else if (tmo) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      we_q        <= 1'b0;
      size_q      <= 3'b000;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      lo_q        <= 32'h0;
      req_ready_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_wmask_q <= 4'b0000;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      we_q        <= we_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lo_q        <= lo_d;
      req_ready_q <= req_ready_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wmask = mem_wmask_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule
